traffic_light_monitor: RTL
==========================

TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

Interface
REQ-001 SHALL have parameter YELLOW_MIN_SEC, default 2: minimum whole one_sec_tick pulses a direction must remain YELLOW.
REQ-002 SHALL have port clk, input, 1: single clock, rising-edge.
REQ-003 SHALL have port reset_n, input, 1: asynchronous active-low reset.
REQ-004 SHALL have port one_sec_tick, input, 1: one-cycle pulse per second from the sec timer.
REQ-005 SHALL have ports n_light, e_light, s_light, w_light, input, 2 each: controller light codes; 00 OFF, 01 RED, 10 YELLOW, 11 GREEN.
REQ-006 SHALL have port clear_fault, input, 1: operator fault clear, level sampled.
REQ-007 SHALL have port fault, output, 1: latched fault flag.
REQ-008 SHALL have port fault_code, output, 3: cause of the latched fault.
REQ-009 SHALL have port fault_dir, output, 2: offending direction; N=0, E=1, S=2, W=3.
REQ-010 SHALL have ports safe_n, safe_e, safe_s, safe_w, output, 2 each: light codes driven to the lamp drivers.

Function
REQ-011 SHALL implement FSM states ARMING, MONITOR, FAULT; ARMING -> MONITOR after exactly one cycle; MONITOR -> FAULT on any detected violation; FAULT -> ARMING when clear_fault=1.
REQ-012 SHALL register all four input codes every cycle as prev codes; violation checks compare current inputs with prev codes.
REQ-013 SHALL flag conflict (code 001) when any of N/S and any of E/W are both non-RED in the same cycle, OFF included.
REQ-014 SHALL flag illegal transition (code 010) when a direction changes GREEN->RED, RED->YELLOW, or YELLOW->GREEN.
REQ-015 SHALL flag dark lamp (code 011) when any direction is OFF.
REQ-016 SHALL resolve simultaneous violations by priority 001 > 010 > 011 > 100, then by lowest fault_dir; for conflict, fault_dir is the lowest non-RED direction.
REQ-017 SHALL assert fault, fault_code and fault_dir on the cycle after the violating inputs are sampled, and hold them unchanged while in FAULT.
REQ-018 SHALL perform no checks in ARMING or FAULT.
REQ-019 SHALL, in MONITOR/ARMING, drive safe_* as the inputs delayed by one register stage.
REQ-020 SHALL, in FAULT, drive all safe_* to RED when the blink bit is 1 and OFF when it is 0; the blink bit is set to 1 on FAULT entry and toggles on each one_sec_tick.
REQ-021 SHALL, when clear_fault and a new violation occur in the same FAULT cycle, let clear win: enter ARMING, deassert fault, and return fault_code and fault_dir to 0.
REQ-022 SHALL ignore clear_fault outside FAULT.

Reset
REQ-023 SHALL, on reset_n=0, asynchronously set: state ARMING, fault 0, fault_code 000, fault_dir 00, all safe_* 01 (RED), prev codes 01, dwell counters 0, blink 1.
REQ-024 SHALL, when reset is asserted mid-FAULT, discard the latched fault with no residual state.

Configuration
REQ-025 SHALL compile the yellow dwell check only when MIN_DWELL_CHECK_EN is defined.
REQ-026 SHALL, with MIN_DWELL_CHECK_EN defined, keep a per-direction 4-bit counter:
- cleared on entry to YELLOW
- incremented per one_sec_tick while YELLOW, saturating at 15
- on YELLOW->RED with count < YELLOW_MIN_SEC, flag code 100
- a tick in the same cycle as the transition is not counted.
REQ-027 SHALL, without MIN_DWELL_CHECK_EN, omit the counters and never produce code 100.

Verification
REQ-028 Legal cycle N GREEN->YELLOW (3 ticks)->RED, others RED -> fault stays 0; safe_n follows n_light one cycle later.
REQ-029 N GREEN with E YELLOW in the same cycle -> next cycle fault=1, fault_code=001, fault_dir=0; safe_* 01/00 alternating per tick.
REQ-030 S GREEN->RED directly -> fault_code=010, fault_dir=2; clear_fault pulse -> fault=0 next cycle, ARMING then MONITOR.
REQ-031 With MIN_DWELL_CHECK_EN and YELLOW_MIN_SEC=2, W YELLOW for 1 tick then RED -> fault_code=100, fault_dir=3; without the macro -> no fault.
REQ-032 Violation and clear_fault in the same FAULT cycle -> fault=0, fault_code=000; reset_n low mid-FAULT -> all outputs at reset values immediately.

Source files
------------

// File: rtl/traffic_light_monitor.sv
// Traffic light safety monitor: latches the first unsafe light pattern and forces blinking RED.
// Optional yellow minimum-dwell check is compiled in with MIN_DWELL_CHECK_EN.
module traffic_light_monitor #(
  parameter int unsigned YELLOW_MIN_SEC = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       one_sec_tick,
  input  logic [1:0] n_light,
  input  logic [1:0] e_light,
  input  logic [1:0] s_light,
  input  logic [1:0] w_light,
  input  logic       clear_fault,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [1:0] fault_dir,
  output logic [1:0] safe_n,
  output logic [1:0] safe_e,
  output logic [1:0] safe_s,
  output logic [1:0] safe_w
);

  localparam int unsigned NUM_DIR = 4;
  localparam int unsigned LW      = 2;
  localparam int unsigned CODE_W  = 3;
  localparam int unsigned DIR_W   = 2;

  localparam logic [LW-1:0] L_OFF = 2'b00;
  localparam logic [LW-1:0] L_RED = 2'b01;
  localparam logic [LW-1:0] L_YEL = 2'b10;
  localparam logic [LW-1:0] L_GRN = 2'b11;

  localparam logic [CODE_W-1:0] C_NONE     = 3'b000;
  localparam logic [CODE_W-1:0] C_CONFLICT = 3'b001;
  localparam logic [CODE_W-1:0] C_ILLEGAL  = 3'b010;
  localparam logic [CODE_W-1:0] C_DARK     = 3'b011;
  localparam logic [CODE_W-1:0] C_DWELL    = 3'b100;

  typedef logic [NUM_DIR-1:0][LW-1:0] lights_t;

  typedef enum logic [1:0] {
    ARMING  = 2'd0,
    MONITOR = 2'd1,
    FAULT   = 2'd2
  } state_t;

  state_t              state;
  lights_t             cur;
  lights_t             prev;
  lights_t             safe_q;
  logic                blink;
  logic [NUM_DIR-1:0]  non_red;
  logic [NUM_DIR-1:0]  bad_step;
  logic [NUM_DIR-1:0]  dark;
  logic [NUM_DIR-1:0]  short_yellow;
  logic [CODE_W-1:0]   viol_code;
  logic [DIR_W-1:0]    viol_dir;

  // Index 0 = N, 1 = E, 2 = S, 3 = W
  assign cur = {w_light, s_light, e_light, n_light};

  function automatic logic [DIR_W-1:0] lowest(input logic [NUM_DIR-1:0] v);
    logic [DIR_W-1:0] r;
    r = '0;
    for (int i = NUM_DIR - 1; i >= 0; i--) begin
      if (v[i]) r = DIR_W'(i);
    end
    return r;
  endfunction

  // Per-direction classification of the current sample against the previous one
  always_comb begin
    non_red  = '0;
    bad_step = '0;
    dark     = '0;
    for (int i = 0; i < NUM_DIR; i++) begin
      non_red[i]  = (cur[i] != L_RED);
      dark[i]     = (cur[i] == L_OFF);
      bad_step[i] = ((prev[i] == L_GRN) && (cur[i] == L_RED)) ||
                    ((prev[i] == L_RED) && (cur[i] == L_YEL)) ||
                    ((prev[i] == L_YEL) && (cur[i] == L_GRN));
    end
  end

`ifdef MIN_DWELL_CHECK_EN
  localparam int unsigned CNT_W = 4;

  logic [NUM_DIR-1:0][CNT_W-1:0] dwell_cnt;

  // Whole ticks spent in YELLOW; the entry cycle clears and ignores a coincident tick
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dwell_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_DIR; i++) begin
        if ((cur[i] == L_YEL) && (prev[i] != L_YEL)) begin
          dwell_cnt[i] <= '0;
        end else if ((cur[i] == L_YEL) && one_sec_tick && (dwell_cnt[i] != '1)) begin
          dwell_cnt[i] <= dwell_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    short_yellow = '0;
    for (int i = 0; i < NUM_DIR; i++) begin
      short_yellow[i] = (prev[i] == L_YEL) && (cur[i] == L_RED) &&
                        (32'(dwell_cnt[i]) < YELLOW_MIN_SEC);
    end
  end
`else
  // Dwell check compiled out; the parameter stays on the interface for drop-in builds
  assign short_yellow = {NUM_DIR{1'b0}} & {NUM_DIR{YELLOW_MIN_SEC != 0}};
`endif

  // Highest-priority violation, only evaluated while monitoring
  always_comb begin
    viol_code = C_NONE;
    viol_dir  = '0;
    if (state == MONITOR) begin
      if ((non_red[0] || non_red[2]) && (non_red[1] || non_red[3])) begin
        viol_code = C_CONFLICT;
        viol_dir  = lowest(non_red);
      end else if (|bad_step) begin
        viol_code = C_ILLEGAL;
        viol_dir  = lowest(bad_step);
      end else if (|dark) begin
        viol_code = C_DARK;
        viol_dir  = lowest(dark);
      end else if (|short_yellow) begin
        viol_code = C_DWELL;
        viol_dir  = lowest(short_yellow);
      end
    end
  end

  // Monitor FSM with registered fault flags and lamp outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ARMING;
      fault      <= 1'b0;
      fault_code <= C_NONE;
      fault_dir  <= '0;
      safe_q     <= {NUM_DIR{L_RED}};
      prev       <= {NUM_DIR{L_RED}};
      blink      <= 1'b1;
    end else begin
      prev <= cur;
      unique case (state)
        ARMING: begin
          state  <= MONITOR;
          safe_q <= cur;
        end
        MONITOR: begin
          if (viol_code != C_NONE) begin
            state      <= FAULT;
            fault      <= 1'b1;
            fault_code <= viol_code;
            fault_dir  <= viol_dir;
            blink      <= 1'b1;
            safe_q     <= {NUM_DIR{L_RED}};
          end else begin
            safe_q <= cur;
          end
        end
        FAULT: begin
          if (clear_fault) begin
            state      <= ARMING;
            fault      <= 1'b0;
            fault_code <= C_NONE;
            fault_dir  <= '0;
            safe_q     <= cur;
          end else if (one_sec_tick) begin
            blink  <= ~blink;
            safe_q <= {NUM_DIR{blink ? L_OFF : L_RED}};
          end else begin
            safe_q <= {NUM_DIR{blink ? L_RED : L_OFF}};
          end
        end
        default: begin
          state <= ARMING;
        end
      endcase
    end
  end

  assign safe_n = safe_q[0];
  assign safe_e = safe_q[1];
  assign safe_s = safe_q[2];
  assign safe_w = safe_q[3];

endmodule
